axi_burst_master: RTL
=====================

# axi_burst_master

Parametrised AXI4 master bridging a CPU/DMA-side request/beat handshake onto the five AXI channel interfaces (inter_RA/RD/WA/WD/WR, Master modports). It issues one INCR burst of 1..MAX_BEATS beats at a time and streams read/write data beat-by-beat with full backpressure. Completion is signalled by a one-cycle done pulse with response status. It replaces the single-beat, stall-based master in the CPU wrapper and serves the DMA port.

## Interface
- MASTER_ID, default 0: value driven on ARID/AWID.
- MAX_BEATS, default 16: maximum burst beats; power of two, 1..256. LW = max(1, $clog2(MAX_BEATS)).
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-low.
- req_valid  input  1  request offered.
- req_ready  output  1  request accepted when req_valid & req_ready.
- req_write  input  1  1 = write burst, 0 = read burst.
- req_addr  input  `AXI_ADDR_BITS  start byte address, word aligned; burst must not cross 4 KB.
- req_len  input  LW  beats minus one.
- req_strb  input  `AXI_STRB_BITS  byte strobe applied to every write beat.
- wd_valid  input  1  write beat available.
- wd_ready  output  1  write beat consumed.
- wd_data  input  `AXI_DATA_BITS  write beat data.
- rd_valid  output  1  read beat valid.
- rd_ready  input  1  consumer accepts read beat.
- rd_data  output  `AXI_DATA_BITS  read beat data.
- rd_last  output  1  final read beat.
- done  output  1  one-cycle completion pulse.
- done_resp  output  2  burst status (OKAY 00 / SLVERR 10 / DECERR 11).
- M_AR, M_R, M_AW, M_W, M_B  interface  -  AXI channels, Master modports.

## Operation
- FSM states: IDLE, RADDR, RDATA, WADDR, WDATA, WRESP.
- IDLE: req_ready = 1. On accept, latch addr/len/strb; go RADDR (read) or WADDR (write).
- RADDR: ARVALID = 1, ARADDR/ARLEN from latches; ARSIZE 3'b010, ARBURST INCR. AR handshake → RDATA.
- RDATA: rd_valid = RVALID, RREADY = rd_ready, rd_data = RDATA, rd_last = RLAST (combinational pass-through). On R handshake with RLAST → IDLE, done = 1.
- WADDR: AWVALID = 1, same field rules. AW handshake → WDATA; W is never driven before AW completes.
- WDATA: WVALID = wd_valid, wd_ready = WREADY, WDATA = wd_data, WSTRB = latched strb, WLAST = (beat_cnt == len_q). On W handshake with WLAST → WRESP.
- WRESP: BREADY = 1. B handshake → IDLE, done = 1.
- beat_cnt: LW+1 bits, cleared on request accept, +1 per R or W handshake; never wraps within a legal burst.
- AXI outputs are 0 and the latch values are held in every state that does not drive them.
- A request offered outside IDLE is not accepted; it must be held until req_ready.

## Timing
- Reset: state IDLE, all VALID/READY outputs 0, req_ready 1 after release, done 0, done_resp 00, rd_* 0, latches and beat_cnt 0.
- Reset asserted mid-burst aborts immediately with no done pulse; the interconnect is reset by the same rst.
- Accept → ARVALID/AWVALID in the next cycle.
- done fires in the cycle after the final R or B handshake. req_ready returns the same cycle as done, so back-to-back requests have 1 idle cycle.
- Zero-wait slave: read of N beats = N+2 cycles accept-to-done; write = N+3.
- Stalls (wd_valid 0, rd_ready 0, slave not ready) extend the burst with no beat loss or duplication.

## Configuration
- AXI_MASTER_RESP_CHECK_EN defined:
  - done_resp = worst (numerically highest) RRESP over all beats, or BRESP.
  - RLAST arriving when beat_cnt != len_q forces done_resp = 10.
  - Read beats past the expected count are still accepted until RLAST and flagged 10.
- Undefined: done_resp tied 00; RRESP/BRESP and beat-count mismatch ignored.

## Structure
- Package axi_master_pkg: state enum, AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR constants, SIZE_WORD = 3'b010, resp-merge function.
- Sub-module axi_beat_cnt: parametrised counter with clear, inc and last-beat compare. Instantiated once.

## Test plan
- Single-beat read, addr 0x0000_1000, slave returns 0xDEADBEEF → one rd beat with rd_last = 1, ARLEN 0, done 3 cycles after accept, done_resp 00.
- Write len = 3, strb 4'b1111, data 1..4, zero-wait slave → four W beats with WLAST only on the 4th, AW strictly before the first W, done_resp 00.
- Read len = 15 with rd_ready toggling every cycle and RVALID random → 16 beats in order, no duplicates, done after RLAST.
- Write with wd_valid gaps and BRESP = 10 → WVALID follows wd_valid; done_resp 10 with the macro defined, 00 without.
- Read len = 3, slave asserts RLAST on beat 2 (macro on) → done_resp 10, FSM back in IDLE.
- rst low during WDATA beat 2 → all VALIDs 0 asynchronously, no done; after release a new read completes normally.

Source files
------------

// File: rtl/axi_master_pkg.sv
// Shared types and AXI constants for the burst master.
// The resp-merge helper is used only when AXI_MASTER_RESP_CHECK_EN is defined.
package axi_master_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RADDR = 3'd1,
        RDATA = 3'd2,
        WADDR = 3'd3,
        WDATA = 3'd4,
        WRESP = 3'd5
    } state_e;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [2:0] SIZE_WORD  = 3'b010;
    localparam logic [1:0] BURST_INCR = 2'b01;

    // Worst response wins; the encodings are ordered by severity.
    function automatic logic [1:0] resp_merge(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_master_if.sv
// AXI4 channel interfaces (AR, R, AW, W, B) with Master/Slave modports.
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif

interface inter_RA;
    logic [`AXI_ID_BITS-1:0]   ARID;
    logic [`AXI_ADDR_BITS-1:0] ARADDR;
    logic [7:0]                ARLEN;
    logic [2:0]                ARSIZE;
    logic [1:0]                ARBURST;
    logic                      ARVALID;
    logic                      ARREADY;
    modport Master (output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, input ARREADY);
    modport Slave  (input ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, output ARREADY);
endinterface

interface inter_RD;
    logic [`AXI_DATA_BITS-1:0] RDATA;
    logic [1:0]                RRESP;
    logic                      RLAST;
    logic                      RVALID;
    logic                      RREADY;
    modport Master (input RDATA, RRESP, RLAST, RVALID, output RREADY);
    modport Slave  (output RDATA, RRESP, RLAST, RVALID, input RREADY);
endinterface

interface inter_WA;
    logic [`AXI_ID_BITS-1:0]   AWID;
    logic [`AXI_ADDR_BITS-1:0] AWADDR;
    logic [7:0]                AWLEN;
    logic [2:0]                AWSIZE;
    logic [1:0]                AWBURST;
    logic                      AWVALID;
    logic                      AWREADY;
    modport Master (output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, input AWREADY);
    modport Slave  (input AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, output AWREADY);
endinterface

interface inter_WD;
    logic [`AXI_DATA_BITS-1:0] WDATA;
    logic [`AXI_STRB_BITS-1:0] WSTRB;
    logic                      WLAST;
    logic                      WVALID;
    logic                      WREADY;
    modport Master (output WDATA, WSTRB, WLAST, WVALID, input WREADY);
    modport Slave  (input WDATA, WSTRB, WLAST, WVALID, output WREADY);
endinterface

interface inter_WR;
    logic [1:0] BRESP;
    logic       BVALID;
    logic       BREADY;
    modport Master (input BRESP, BVALID, output BREADY);
    modport Slave  (output BRESP, BVALID, input BREADY);
endinterface

// File: rtl/axi_beat_cnt.sv
// Beat counter: cleared on request accept, counts handshakes, flags the final beat.
module axi_beat_cnt #(
    parameter int LW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          inc_i,
    input  logic [LW-1:0] len_i,
    output logic          last_o
);

    logic [LW:0] cnt_q, cnt_d;

    // Next count: clear takes priority over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + {{LW{1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == {1'b0, len_i});

endmodule

// File: rtl/axi_burst_master.sv
// AXI4 INCR burst master: one burst at a time, beat-level handshake on the client side.
// Define AXI_MASTER_RESP_CHECK_EN to report RRESP/BRESP and read beat-count errors on done_resp.
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif

module axi_burst_master
    import axi_master_pkg::*;
#(
    parameter int MASTER_ID = 0,
    parameter int MAX_BEATS = 16,
    localparam int LW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [`AXI_ADDR_BITS-1:0] req_addr,
    input  logic [LW-1:0]             req_len,
    input  logic [`AXI_STRB_BITS-1:0] req_strb,
    input  logic                      wd_valid,
    output logic                      wd_ready,
    input  logic [`AXI_DATA_BITS-1:0] wd_data,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic [`AXI_DATA_BITS-1:0] rd_data,
    output logic                      rd_last,
    output logic                      done,
    output logic [1:0]                done_resp,
    inter_RA.Master                   M_AR,
    inter_RD.Master                   M_R,
    inter_WA.Master                   M_AW,
    inter_WD.Master                   M_W,
    inter_WR.Master                   M_B
);

    localparam int IDW = `AXI_ID_BITS;
    localparam logic [IDW-1:0] AXI_ID = IDW'(MASTER_ID);

    state_e                    state_q, state_d;
    logic [`AXI_ADDR_BITS-1:0] addr_q, addr_d;
    logic [LW-1:0]             len_q, len_d;
    logic [`AXI_STRB_BITS-1:0] strb_q, strb_d;
    logic                      done_q, done_d;
    logic [1:0]                done_resp_q, done_resp_d;
    logic                      cnt_clr_s, cnt_inc_s, cnt_last_s;
    logic                      req_ready_s, arvalid_s, awvalid_s, rready_s, wvalid_s, bready_s;
    logic                      wd_ready_s, rd_valid_s, rd_last_s, wlast_s;
    logic [`AXI_DATA_BITS-1:0] rd_data_s, wdata_s;
    logic [`AXI_STRB_BITS-1:0] wstrb_s;
`ifdef AXI_MASTER_RESP_CHECK_EN
    logic [1:0]                resp_acc_q, resp_acc_d, beat_resp_s;
    logic                      past_last_q, past_last_d;
`endif

    // Next-state, latch updates and all channel controls.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        strb_d      = strb_q;
        done_d      = 1'b0;
        done_resp_d = done_resp_q;
        cnt_clr_s   = 1'b0;
        cnt_inc_s   = 1'b0;
        req_ready_s = 1'b0;
        arvalid_s   = 1'b0;
        awvalid_s   = 1'b0;
        rready_s    = 1'b0;
        wvalid_s    = 1'b0;
        bready_s    = 1'b0;
        wd_ready_s  = 1'b0;
        rd_valid_s  = 1'b0;
        rd_last_s   = 1'b0;
        wlast_s     = 1'b0;
        rd_data_s   = '0;
        wdata_s     = '0;
        wstrb_s     = '0;
`ifdef AXI_MASTER_RESP_CHECK_EN
        resp_acc_d  = resp_acc_q;
        past_last_d = past_last_q;
        beat_resp_s = AXI_RESP_OKAY;
`endif
        case (state_q)
            IDLE: begin
                req_ready_s = 1'b1;
                if (req_valid) begin
                    addr_d    = req_addr;
                    len_d     = req_len;
                    strb_d    = req_strb;
                    cnt_clr_s = 1'b1;
`ifdef AXI_MASTER_RESP_CHECK_EN
                    resp_acc_d  = AXI_RESP_OKAY;
                    past_last_d = 1'b0;
`endif
                    state_d = req_write ? WADDR : RADDR;
                end else begin
                    state_d = IDLE;
                end
            end
            RADDR: begin
                arvalid_s = 1'b1;
                if (M_AR.ARREADY) begin
                    state_d = RDATA;
                end else begin
                    state_d = RADDR;
                end
            end
            RDATA: begin
                rd_valid_s = M_R.RVALID;
                rready_s   = rd_ready;
                rd_data_s  = M_R.RDATA;
                rd_last_s  = M_R.RLAST;
                if (M_R.RVALID && rd_ready) begin
                    cnt_inc_s = 1'b1;
`ifdef AXI_MASTER_RESP_CHECK_EN
                    // Early RLAST or any beat after the expected last one is a slave error.
                    if (past_last_q || (M_R.RLAST && !cnt_last_s)) begin
                        beat_resp_s = resp_merge(M_R.RRESP, AXI_RESP_SLVERR);
                    end else begin
                        beat_resp_s = M_R.RRESP;
                    end
                    resp_acc_d  = resp_merge(resp_acc_q, beat_resp_s);
                    past_last_d = past_last_q | cnt_last_s;
`endif
                    if (M_R.RLAST) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
`ifdef AXI_MASTER_RESP_CHECK_EN
                        done_resp_d = resp_acc_d;
`else
                        done_resp_d = AXI_RESP_OKAY;
`endif
                    end else begin
                        state_d = RDATA;
                    end
                end else begin
                    state_d = RDATA;
                end
            end
            WADDR: begin
                awvalid_s = 1'b1;
                if (M_AW.AWREADY) begin
                    state_d = WDATA;
                end else begin
                    state_d = WADDR;
                end
            end
            WDATA: begin
                wvalid_s   = wd_valid;
                wd_ready_s = M_W.WREADY;
                wdata_s    = wd_data;
                wstrb_s    = strb_q;
                wlast_s    = cnt_last_s;
                if (wd_valid && M_W.WREADY) begin
                    cnt_inc_s = 1'b1;
                    state_d   = cnt_last_s ? WRESP : WDATA;
                end else begin
                    state_d = WDATA;
                end
            end
            WRESP: begin
                bready_s = 1'b1;
                if (M_B.BVALID) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
`ifdef AXI_MASTER_RESP_CHECK_EN
                    done_resp_d = resp_merge(resp_acc_q, M_B.BRESP);
`else
                    done_resp_d = AXI_RESP_OKAY;
`endif
                end else begin
                    state_d = WRESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, request latches and completion status.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            strb_q      <= '0;
            done_q      <= 1'b0;
            done_resp_q <= AXI_RESP_OKAY;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            strb_q      <= strb_d;
            done_q      <= done_d;
            done_resp_q <= done_resp_d;
        end
    end

`ifdef AXI_MASTER_RESP_CHECK_EN
    // Running response accumulator for the burst in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_acc_q  <= AXI_RESP_OKAY;
            past_last_q <= 1'b0;
        end else begin
            resp_acc_q  <= resp_acc_d;
            past_last_q <= past_last_d;
        end
    end
`endif

    axi_beat_cnt #(.LW(LW)) u_beat_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (cnt_clr_s),
        .inc_i  (cnt_inc_s),
        .len_i  (len_q),
        .last_o (cnt_last_s)
    );

    assign req_ready = req_ready_s;
    assign wd_ready  = wd_ready_s;
    assign rd_valid  = rd_valid_s;
    assign rd_data   = rd_data_s;
    assign rd_last   = rd_last_s;
    assign done      = done_q;
    assign done_resp = done_resp_q;

    // Address-channel fields read zero whenever their VALID is low.
    assign M_AR.ARVALID = arvalid_s;
    assign M_AR.ARID    = arvalid_s ? AXI_ID : '0;
    assign M_AR.ARADDR  = arvalid_s ? addr_q : '0;
    assign M_AR.ARLEN   = arvalid_s ? 8'(len_q) : 8'h00;
    assign M_AR.ARSIZE  = arvalid_s ? SIZE_WORD : 3'b000;
    assign M_AR.ARBURST = arvalid_s ? BURST_INCR : 2'b00;
    assign M_R.RREADY   = rready_s;

    assign M_AW.AWVALID = awvalid_s;
    assign M_AW.AWID    = awvalid_s ? AXI_ID : '0;
    assign M_AW.AWADDR  = awvalid_s ? addr_q : '0;
    assign M_AW.AWLEN   = awvalid_s ? 8'(len_q) : 8'h00;
    assign M_AW.AWSIZE  = awvalid_s ? SIZE_WORD : 3'b000;
    assign M_AW.AWBURST = awvalid_s ? BURST_INCR : 2'b00;

    assign M_W.WVALID = wvalid_s;
    assign M_W.WDATA  = wdata_s;
    assign M_W.WSTRB  = wstrb_s;
    assign M_W.WLAST  = wlast_s;
    assign M_B.BREADY = bready_s;

endmodule
